// File: rtl/jk_ff_df.sv
// Bank of independent positive-edge JK flip-flops with asynchronous active-low
// reset, a complementary output and a registered per-bit "changed" flag.
module jk_ff_df #(
   parameter int                     WIDTH       = 1,
   parameter logic [WIDTH-1:0]       RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] J,
   input  logic [WIDTH-1:0] K,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qn,
   output logic [WIDTH-1:0] changed
);

   logic [WIDTH-1:0] q_next;

   // Characteristic equation covers hold, clear, set and toggle per bit.
   assign q_next = (J & ~Q) | (~K & Q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Q       <= RESET_VALUE;
         changed <= '0;
      end else begin
         Q       <= q_next;
         changed <= q_next ^ Q;
      end
   end

   assign Qn = ~Q;

endmodule

// File: tb/tb_jk_ff_df.sv
// Directed bench for jk_ff_df: a 1-bit and a 4-bit instance checked every cycle
// against a truth-table model, plus hand-computed literal expectations.
module tb_jk_ff_df;

   localparam logic [3:0] RV4 = 4'b1010;

   logic       clk = 1'b0;
   logic       reset1;
   logic       reset4;
   logic [0:0] j1, k1;
   logic [0:0] q1, qn1, ch1;
   logic [3:0] j4, k4;
   logic [3:0] q4, qn4, ch4;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_q[$];

   // Truth-table model state
   logic [0:0] m1_q, m1_ch;
   logic [3:0] m4_q, m4_ch;

   jk_ff_df u_dut1 (
      .clk     (clk),
      .reset   (reset1),
      .J       (j1),
      .K       (k1),
      .Q       (q1),
      .Qn      (qn1),
      .changed (ch1)
   );

   jk_ff_df #(.WIDTH(4), .RESET_VALUE(RV4)) u_dut4 (
      .clk     (clk),
      .reset   (reset4),
      .J       (j4),
      .K       (k4),
      .Q       (q4),
      .Qn      (qn4),
      .changed (ch4)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #20000;
      $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
      $fatal(1);
   end

   function automatic logic jk_rule(input logic cur, input logic j, input logic k);
      case ({j, k})
         2'b00:   return cur;
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return !cur;
      endcase
   endfunction

   always @(posedge clk or negedge reset1) begin
      if (!reset1) begin
         m1_q  = 1'b0;
         m1_ch = 1'b0;
      end else begin
         logic nxt;
         nxt   = jk_rule(m1_q[0], j1[0], k1[0]);
         m1_ch = (nxt != m1_q[0]);
         m1_q  = nxt;
      end
   end

   always @(posedge clk or negedge reset4) begin
      if (!reset4) begin
         m4_q  = RV4;
         m4_ch = 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            logic nxt;
            nxt      = jk_rule(m4_q[i], j4[i], k4[i]);
            m4_ch[i] = (nxt != m4_q[i]);
            m4_q[i]  = nxt;
         end
      end
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model
   always @(negedge clk) begin
      check("q1_model",   {3'b0, q1},   {3'b0, m1_q});
      check("qn1_model",  {3'b0, qn1},  {3'b0, ~m1_q});
      check("ch1_model",  {3'b0, ch1},  {3'b0, m1_ch});
      check("q4_model",   q4,           m4_q);
      check("qn4_model",  qn4,          ~m4_q);
      check("ch4_model",  ch4,          m4_ch);
   end

   // Driver: called at a falling edge, applies J/K for exactly one rising edge.
   task automatic step1(input logic j, input logic k, input logic [3:0] exp_after);
      exp_q.push_back(exp_after);
      #1;
      j1 = j;
      k1 = k;
      @(negedge clk);
   endtask

   task automatic pop_check(input string name);
      logic [3:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: expectation queue empty, got %b", name, q1);
      end else begin
         e = exp_q.pop_front();
         check({name, "_dut"},   {3'b0, q1},   e);
         check({name, "_model"}, {3'b0, m1_q}, e);
      end
   endtask

   initial begin
      reset1 = 1'b0;
      reset4 = 1'b0;
      j1 = 1'b1;
      k1 = 1'b1;
      j4 = 4'b0000;
      k4 = 4'b0000;

      // Reset held across two edges with J=K=1
      @(negedge clk);
      @(negedge clk);
      check("rst_q1",  {3'b0, q1},  4'b0000);
      check("rst_qn1", {3'b0, qn1}, 4'b0001);
      check("rst_ch1", {3'b0, ch1}, 4'b0000);
      check("rst_q4",  q4,  4'b1010);
      check("rst_qn4", qn4, 4'b0101);
      check("rst_ch4", ch4, 4'b0000);

      #1;
      reset1 = 1'b1;
      reset4 = 1'b1;
      step1(1'b0, 1'b0, 4'b0000);
      pop_check("release_hold");

      step1(1'b0, 1'b1, 4'b0000);
      pop_check("clear");
      check("clear_ch", {3'b0, ch1}, 4'b0000);

      step1(1'b1, 1'b0, 4'b0001);
      pop_check("set");
      check("set_qn", {3'b0, qn1}, 4'b0000);
      check("set_ch", {3'b0, ch1}, 4'b0001);

      step1(1'b1, 1'b1, 4'b0000);
      pop_check("toggle_a");
      check("toggle_a_ch", {3'b0, ch1}, 4'b0001);
      step1(1'b1, 1'b1, 4'b0001);
      pop_check("toggle_b");
      check("toggle_b_ch", {3'b0, ch1}, 4'b0001);

      step1(1'b0, 1'b0, 4'b0001);
      pop_check("hold");
      check("hold_ch", {3'b0, ch1}, 4'b0000);

      // Asynchronous reset between edges
      #2;
      reset1 = 1'b0;
      #1;
      check("async_q1",  {3'b0, q1},  4'b0000);
      check("async_qn1", {3'b0, qn1}, 4'b0001);
      check("async_ch1", {3'b0, ch1}, 4'b0000);
      @(negedge clk);
      #1;
      reset1 = 1'b1;

      // Wide instance: mixed toggle/set/clear/hold in one edge
      j4 = 4'b0011;
      k4 = 4'b0101;
      @(negedge clk);
      check("wide_q4",  q4,  4'b1011);
      check("wide_qn4", qn4, 4'b0100);
      check("wide_ch4", ch4, 4'b0001);
      #1;
      j4 = 4'b0000;
      k4 = 4'b0000;
      @(negedge clk);
      check("wide_hold_q4",  q4,  4'b1011);
      check("wide_hold_ch4", ch4, 4'b0000);

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
